retire_ctrl: RTL and testbench

RETIRE_CTRL -- requirements
Module: retire_ctrl

---
 rtl/sys_defs.sv | 27 ++
 rtl/retire_select.sv | 27 ++
 rtl/retire_ctrl.sv | 146 ++++++++++++++
 tb/tb_retire_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared types for the retirement stage: ROB head entry layout, retire FSM
// states and the machine-wide width constants.
package sys_defs;

   localparam int XLEN   = 32;
   localparam int PREG_W = 6;
   localparam int AREG_W = 5;

   typedef struct packed {
      logic              completed;
      logic              precise_state_need;
      logic [XLEN-1:0]   target_pc;
      logic [AREG_W-1:0] arch_reg;
      logic [PREG_W-1:0] t_new;
      logic [PREG_W-1:0] t_old;
      logic              is_store;
      logic              halt;
   } ROB_ENTRY_PACKET;

   typedef enum logic [1:0] {
      RUN,
      RECOVER,
      FLUSH,
      HALTED
   } retire_state_e;

endpackage

// File: rtl/retire_select.sv
// In-order retire selection: a slot retires only if every older slot retired
// and none of them stopped the group (slot RETIRE_W-1 is the oldest).
module retire_select #(
   parameter int RETIRE_W = 3
) (
   input  logic                enable_i,
   input  logic [RETIRE_W-1:0] valid_i,
   input  logic [RETIRE_W-1:0] completed_i,
   input  logic [RETIRE_W-1:0] stop_i,
   output logic [RETIRE_W-1:0] retire_en_o
);

   logic allow;

   // NOTE: blocking assignments are correct here; the chain value must ripple
   // from oldest to youngest within one evaluation, and every variable gets a
   // default first so no latch is inferred.
   always_comb begin
      allow       = enable_i;
      retire_en_o = '0;
      for (int i = RETIRE_W - 1; i >= 0; i--) begin
         retire_en_o[i] = allow & valid_i[i] & completed_i[i];
         allow          = retire_en_o[i] & ~stop_i[i];
      end
   end

endmodule

// File: rtl/retire_ctrl.sv
// ROB retirement controller: commits up to RETIRE_W head entries per cycle,
// maintains the architectural map and sequences recovery, flush and halt.
module retire_ctrl
   import sys_defs::*;
#(
   parameter int RETIRE_W     = 3,
   parameter int PR_W         = PREG_W,
   parameter int FLUSH_CYCLES = 2,
   parameter int ARCH_REGS    = 32
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic            [RETIRE_W-1:0]         head_valid,
   input  ROB_ENTRY_PACKET [RETIRE_W-1:0]         head_entry,
   output logic            [RETIRE_W-1:0]         retire_en,
   output logic            [RETIRE_W-1:0]         fl_ret_valid,
   output logic            [RETIRE_W-1:0][PR_W-1:0] fl_ret_preg,
   output logic            [$clog2(RETIRE_W+1)-1:0] sq_retire_cnt,
   output logic                                   br_recover_en,
   output logic            [XLEN-1:0]             target_pc,
   output logic            [ARCH_REGS-1:0][PR_W-1:0] archi_maptable,
   output logic            [ARCH_REGS-1:0][PR_W-1:0] recover_maptable,
   output logic                                   halt
);

   localparam int SQ_W  = $clog2(RETIRE_W + 1);
   localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] FLUSH_LOAD =
      (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

   retire_state_e                  state_q;
   logic [CNT_W-1:0]               flush_cnt_q;
   logic                           br_recover_en_q;
   logic                           halt_q;
   logic [XLEN-1:0]                target_pc_q;
   logic [ARCH_REGS-1:0][PR_W-1:0] map_q;
   logic [ARCH_REGS-1:0][PR_W-1:0] map_d;

   logic [RETIRE_W-1:0] completed_v;
   logic [RETIRE_W-1:0] stop_v;
   logic [SQ_W-1:0]     sq_cnt_d;
   logic                halt_hit;
   logic                redirect_hit;
   logic [XLEN-1:0]     redirect_pc;

   always_comb begin
      completed_v = '0;
      stop_v      = '0;
      for (int i = 0; i < RETIRE_W; i++) begin
         completed_v[i] = head_entry[i].completed;
         stop_v[i]      = head_entry[i].precise_state_need | head_entry[i].halt;
      end
   end

   retire_select #(
      .RETIRE_W (RETIRE_W)
   ) u_retire_select (
      .enable_i    (state_q == RUN),
      .valid_i     (head_valid),
      .completed_i (completed_v),
      .stop_i      (stop_v),
      .retire_en_o (retire_en)
   );

   // Walking oldest to youngest lets the youngest writer of a register win.
   always_comb begin
      map_d        = map_q;
      sq_cnt_d     = '0;
      halt_hit     = 1'b0;
      redirect_hit = 1'b0;
      redirect_pc  = '0;
      fl_ret_valid = '0;
      fl_ret_preg  = '0;
      for (int i = RETIRE_W - 1; i >= 0; i--) begin
         fl_ret_preg[i]  = PR_W'(head_entry[i].t_old);
         fl_ret_valid[i] = retire_en[i] && (head_entry[i].arch_reg != '0);
         if (fl_ret_valid[i]) begin
            map_d[head_entry[i].arch_reg] = PR_W'(head_entry[i].t_new);
         end
         if (retire_en[i] && head_entry[i].is_store) begin
            sq_cnt_d = sq_cnt_d + SQ_W'(1);
         end
         if (retire_en[i] && head_entry[i].halt) begin
            halt_hit = 1'b1;
         end else if (retire_en[i] && head_entry[i].precise_state_need) begin
            redirect_hit = 1'b1;
            redirect_pc  = head_entry[i].target_pc;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= RUN;
         flush_cnt_q     <= '0;
         br_recover_en_q <= 1'b0;
         target_pc_q     <= '0;
         halt_q          <= 1'b0;
         // NOTE: the map is real architectural state, so every entry is reset
         // to the identity mapping rather than left to power-up garbage.
         for (int r = 0; r < ARCH_REGS; r++) begin
            map_q[r] <= PR_W'(r);
         end
      end else begin
         map_q <= map_d;
         case (state_q)
            RUN: begin
               if (halt_hit) begin
                  state_q <= HALTED;
                  halt_q  <= 1'b1;
               end else if (redirect_hit) begin
                  state_q         <= RECOVER;
                  br_recover_en_q <= 1'b1;
                  target_pc_q     <= redirect_pc;
               end
            end
            RECOVER: begin
               br_recover_en_q <= 1'b0;
               if (FLUSH_CYCLES > 0) begin
                  state_q     <= FLUSH;
                  flush_cnt_q <= FLUSH_LOAD;
               end else begin
                  state_q <= RUN;
               end
            end
            FLUSH: begin
               if (flush_cnt_q == '0) begin
                  state_q <= RUN;
               end else begin
                  flush_cnt_q <= flush_cnt_q - CNT_W'(1);
               end
            end
            HALTED:  state_q <= HALTED;
            default: state_q <= RUN;
         endcase
      end
   end

   assign sq_retire_cnt    = sq_cnt_d;
   assign br_recover_en    = br_recover_en_q;
   assign target_pc        = target_pc_q;
   assign archi_maptable   = map_q;
   assign recover_maptable = map_q;
   assign halt             = halt_q;

endmodule

// File: tb/tb_retire_ctrl.sv
// Directed and randomized checks of retire_ctrl against a cycle-level
// behavioural model of the retirement rules.
module tb_retire_ctrl;
   import sys_defs::*;

   localparam int W  = 3;
   localparam int PW = 6;
   localparam int FC = 2;
   localparam int AR = 32;

   typedef logic [191:0] chk_t;

   logic                          clock = 1'b0;
   logic                          reset;
   logic            [W-1:0]       head_valid;
   ROB_ENTRY_PACKET [W-1:0]       head_entry;
   logic            [W-1:0]       retire_en;
   logic            [W-1:0]       fl_ret_valid;
   logic            [W-1:0][PW-1:0] fl_ret_preg;
   logic            [1:0]         sq_retire_cnt;
   logic                          br_recover_en;
   logic            [XLEN-1:0]    target_pc;
   logic            [AR-1:0][PW-1:0] archi_maptable;
   logic            [AR-1:0][PW-1:0] recover_maptable;
   logic                          halt;

   retire_ctrl #(
      .RETIRE_W     (W),
      .PR_W         (PW),
      .FLUSH_CYCLES (FC),
      .ARCH_REGS    (AR)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .head_valid       (head_valid),
      .head_entry       (head_entry),
      .retire_en        (retire_en),
      .fl_ret_valid     (fl_ret_valid),
      .fl_ret_preg      (fl_ret_preg),
      .sq_retire_cnt    (sq_retire_cnt),
      .br_recover_en    (br_recover_en),
      .target_pc        (target_pc),
      .archi_maptable   (archi_maptable),
      .recover_maptable (recover_maptable),
      .halt             (halt)
   );

   always #5 clock = ~clock;

   int vectors    = 0;
   int checks     = 0;
   int miscompares = 0;

   // reference model state
   logic [PW-1:0] mdl_map [AR];
   bit            mdl_halted;
   bit            mdl_rec;
   int            mdl_flush;
   logic [31:0]   mdl_pc;
   bit            mdl_running;
   logic [W-1:0]  exp_ret;
   logic [W-1:0]  exp_flv;
   int            exp_cnt;
   int            exp_stop;

   task automatic check(input string tag, input chk_t obs, input chk_t exp);
      checks++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic chk_t model_map_vec();
      chk_t v = '0;
      for (int r = 0; r < AR; r++) v[r*PW +: PW] = mdl_map[r];
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < AR; r++) mdl_map[r] = PW'(r);
      mdl_halted = 0;
      mdl_rec    = 0;
      mdl_flush  = 0;
      mdl_pc     = '0;
   endtask

   task automatic model_comb();
      mdl_running = !mdl_halted && !mdl_rec && (mdl_flush == 0);
      exp_ret  = '0;
      exp_flv  = '0;
      exp_cnt  = 0;
      exp_stop = -1;
      if (mdl_running) begin
         for (int i = W - 1; i >= 0; i--) begin
            if (!(head_valid[i] && head_entry[i].completed)) break;
            exp_ret[i] = 1'b1;
            if (head_entry[i].precise_state_need || head_entry[i].halt) begin
               exp_stop = i;
               break;
            end
         end
      end
      for (int i = 0; i < W; i++) begin
         exp_flv[i] = exp_ret[i] && (head_entry[i].arch_reg != 0);
         if (exp_ret[i] && head_entry[i].is_store) exp_cnt++;
      end
   endtask

   task automatic model_update();
      if (mdl_running) begin
         for (int i = W - 1; i >= 0; i--)
            if (exp_flv[i]) mdl_map[head_entry[i].arch_reg] = head_entry[i].t_new;
         if (exp_stop >= 0) begin
            if (head_entry[exp_stop].halt) mdl_halted = 1;
            else begin
               mdl_rec = 1;
               mdl_pc  = head_entry[exp_stop].target_pc;
            end
         end
      end else if (mdl_rec) begin
         mdl_rec   = 0;
         mdl_flush = FC;
      end else if (mdl_flush > 0) begin
         mdl_flush--;
      end
   endtask

   task automatic check_regs(input string ph);
      check({ph, "_br"}, chk_t'(br_recover_en), chk_t'(mdl_rec));
      check({ph, "_halt"}, chk_t'(halt), chk_t'(mdl_halted));
      check({ph, "_map"}, chk_t'(archi_maptable), model_map_vec());
      if (mdl_rec) begin
         check({ph, "_pc"}, chk_t'(target_pc), chk_t'(mdl_pc));
         check({ph, "_recmap"}, chk_t'(recover_maptable), model_map_vec());
      end
   endtask

   // One clock: combinational outputs checked mid-cycle, registers after the edge.
   task automatic step();
      logic [W-1:0][PW-1:0] obs_p;
      logic [W-1:0][PW-1:0] exp_p;
      vectors++;
      model_comb();
      @(negedge clock);
      obs_p = '0;
      exp_p = '0;
      for (int i = 0; i < W; i++) begin
         if (exp_flv[i]) begin
            obs_p[i] = fl_ret_preg[i];
            exp_p[i] = head_entry[i].t_old;
         end
      end
      check("retire_en", chk_t'(retire_en), chk_t'(exp_ret));
      check("fl_ret_valid", chk_t'(fl_ret_valid), chk_t'(exp_flv));
      check("fl_ret_preg", chk_t'(obs_p), chk_t'(exp_p));
      check("sq_retire_cnt", chk_t'(sq_retire_cnt), chk_t'(exp_cnt));
      @(posedge clock);
      model_update();
      #1;
      check_regs("post");
   endtask

   task automatic do_reset();
      head_valid = '0;
      reset = 1'b1;
      #2;
      model_reset();
      check("rst_br", chk_t'(br_recover_en), chk_t'(0));
      check("rst_halt", chk_t'(halt), chk_t'(0));
      check("rst_pc", chk_t'(target_pc), chk_t'(0));
      check("rst_map", chk_t'(archi_maptable), model_map_vec());
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic clear_slots();
      head_valid = '0;
      head_entry = '0;
   endtask

   task automatic put(input int s, input bit c, input bit psn, input bit h,
                      input logic [31:0] pc, input logic [4:0] arch,
                      input logic [5:0] tn, input logic [5:0] to, input bit st);
      head_valid[s]                    = 1'b1;
      head_entry[s].completed          = c;
      head_entry[s].precise_state_need = psn;
      head_entry[s].halt               = h;
      head_entry[s].target_pc          = pc;
      head_entry[s].arch_reg           = arch;
      head_entry[s].t_new              = tn;
      head_entry[s].t_old              = to;
      head_entry[s].is_store           = st;
   endtask

   task automatic put_plain3();
      clear_slots();
      put(2, 1, 0, 0, 32'h0, 5'd7, 6'd30, 6'd50, 1'b0);
      put(1, 1, 0, 0, 32'h0, 5'd8, 6'd31, 6'd51, 1'b1);
      put(0, 1, 0, 0, 32'h0, 5'd9, 6'd32, 6'd52, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      clear_slots();
      @(posedge clock);
      #1;
      do_reset();

      // three-wide retire
      clear_slots();
      put(2, 1, 0, 0, 32'h0, 5'd1, 6'd10, 6'd40, 1'b0);
      put(1, 1, 0, 0, 32'h0, 5'd2, 6'd11, 6'd41, 1'b1);
      put(0, 1, 0, 0, 32'h0, 5'd3, 6'd12, 6'd42, 1'b1);
      step();
      check("map1_is_10", chk_t'(archi_maptable[1]), chk_t'(10));
      check("map3_is_12", chk_t'(archi_maptable[3]), chk_t'(12));

      // mispredict in the oldest slot, then recover and flush
      clear_slots();
      put(2, 1, 1, 0, 32'h8000_0000, 5'd4, 6'd13, 6'd43, 1'b0);
      put(1, 1, 0, 0, 32'h0, 5'd5, 6'd14, 6'd44, 1'b0);
      put(0, 1, 0, 0, 32'h0, 5'd6, 6'd15, 6'd45, 1'b0);
      step();
      check("recover_pc", chk_t'(target_pc), chk_t'(32'h8000_0000));
      check("recover_pulse", chk_t'(br_recover_en), chk_t'(1));
      check("recover_map4", chk_t'(recover_maptable[4]), chk_t'(13));
      put_plain3();
      step();
      step();
      step();
      step();

      // incomplete oldest slot blocks everything
      clear_slots();
      put(2, 0, 0, 0, 32'h0, 5'd10, 6'd16, 6'd46, 1'b0);
      put(1, 1, 0, 0, 32'h0, 5'd11, 6'd17, 6'd47, 1'b0);
      put(0, 1, 0, 0, 32'h0, 5'd12, 6'd18, 6'd48, 1'b0);
      step();

      // same-register collision, youngest wins
      clear_slots();
      put(2, 1, 0, 0, 32'h0, 5'd5, 6'd20, 6'd24, 1'b0);
      put(1, 1, 0, 0, 32'h0, 5'd5, 6'd21, 6'd25, 1'b0);
      step();
      check("collision_map5", chk_t'(archi_maptable[5]), chk_t'(21));

      // reset during the first flush cycle
      clear_slots();
      put(2, 1, 1, 0, 32'h1234_5678, 5'd0, 6'd22, 6'd26, 1'b0);
      step();
      clear_slots();
      step();
      do_reset();
      put_plain3();
      step();

      // halt in the middle slot
      clear_slots();
      put(2, 1, 0, 0, 32'h0, 5'd13, 6'd33, 6'd53, 1'b0);
      put(1, 1, 1, 1, 32'hdead_beef, 5'd14, 6'd34, 6'd54, 1'b0);
      put(0, 1, 0, 0, 32'h0, 5'd15, 6'd35, 6'd55, 1'b0);
      step();
      put_plain3();
      for (int k = 0; k < 3; k++) step();
      check("halt_sticky", chk_t'(halt), chk_t'(1));
      do_reset();
      check("halt_cleared", chk_t'(halt), chk_t'(0));

      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         clear_slots();
         for (int s = 0; s < W; s++) begin
            head_valid[s]                    = ($urandom % 8) != 0;
            head_entry[s].completed          = ($urandom % 4) != 0;
            head_entry[s].precise_state_need = ($urandom % 10) == 0;
            head_entry[s].halt               = ($urandom % 40) == 0;
            head_entry[s].target_pc          = $urandom;
            head_entry[s].arch_reg           = 5'($urandom_range(0, 31));
            head_entry[s].t_new              = 6'($urandom_range(0, 63));
            head_entry[s].t_old              = 6'($urandom_range(0, 63));
            head_entry[s].is_store           = 1'($urandom % 2);
         end
         step();
         if ((mdl_halted && ($urandom % 4) == 0) || ($urandom % 60) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
